instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the memory's instruction port. Drives the

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Drives the instruction memory address from the
// fetch PC and decodes RV32C vs 32-bit length from the returned word. The PC
// advances by 2 or 4, and each fetched {pc, instr, is_c} goes into a small
// FIFO. Decode drains the FIFO with valid/ready. A redirect flushes the FIFO
// and restarts fetch at the target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] IMemAddr_o,
  input  logic [31:0] IMemData_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_c_o
);

  // DEPTH is a power of two, so pointers wrap naturally at PW bits.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  // The FIFO is held in registers so that reset can clear the head outputs.
  logic [31:0] mem_pc_q    [DEPTH];
  logic [31:0] mem_pc_d    [DEPTH];
  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_instr_d [DEPTH];
  logic        mem_c_q     [DEPTH];
  logic        mem_c_d     [DEPTH];

  logic        is_c;
  logic [31:0] fetch_instr;
  logic        valid;
  logic        pop;
  logic        push;

  // Length decode of the word at fetch_pc, and handshake terms.
  always_comb begin
    is_c        = (IMemData_i[1:0] != 2'b11);
    fetch_instr = is_c ? {16'h0000, IMemData_i[15:0]} : IMemData_i;
    // A redirect hides the head, so no handshake completes in that cycle.
    valid       = (count_q != '0) & ~redirect_i;
    pop         = valid & instr_ready_i;
    // When full, a simultaneous pop frees the slot that the push uses.
    push        = ~redirect_i & ((count_q < CW'(DEPTH)) | pop);
  end

  // Next-state logic for the fetch PC, the pointers and the occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:1], 1'b0};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + (is_c ? 32'd2 : 32'd4);
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Write the fetched entry into the slot at the write pointer.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_pc_d[i]    = mem_pc_q[i];
      mem_instr_d[i] = mem_instr_q[i];
      mem_c_d[i]     = mem_c_q[i];
      if (push && (wr_ptr_q == PW'(i))) begin
        mem_pc_d[i]    = fetch_pc_q;
        mem_instr_d[i] = fetch_instr;
        mem_c_d[i]     = is_c;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage registers. These are cleared on reset so the head reads 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
        mem_c_q[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= mem_pc_d[i];
        mem_instr_q[i] <= mem_instr_d[i];
        mem_c_q[i]     <= mem_c_d[i];
      end
    end
  end

  // The memory address is always the fetch PC. The head is read from the register.
  always_comb begin
    IMemAddr_o    = fetch_pc_q;
    instr_valid_o = valid;
    instr_o       = mem_instr_q[rd_ptr_q];
    instr_pc_o    = mem_pc_q[rd_ptr_q];
    instr_is_c_o  = mem_c_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A queue-based model of the fetch stage
// is compared with the DUT on every falling edge. Directed scenarios use
// literal expectations, and a randomized phase follows them.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        is_c;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .IMemAddr_o    (imem_addr),
    .IMemData_i    (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_is_c_o  (is_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Halfword-addressed memory of 2 KiB. Higher address bits alias.
  logic [15:0] mem_h [0:1023];
  logic [9:0]  ia0, ia1;
  assign ia0 = imem_addr[10:1];
  assign ia1 = ia0 + 10'd1;
  always_comb imem_data = {mem_h[ia1], mem_h[ia0]};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [9:0] i0;
    logic [9:0] i1;
    i0 = a[10:1];
    i1 = i0 + 10'd1;
    return {mem_h[i1], mem_h[i0]};
  endfunction

  task automatic put16(input logic [31:0] a, input logic [15:0] h);
    mem_h[a[10:1]] = h;
  endtask

  task automatic put32(input logic [31:0] a, input logic [31:0] w);
    put16(a, w[15:0]);
    put16(a + 32'd2, w[31:16]);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is a queue, and the PC is a plain 32-bit value.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  always @(posedge clk or negedge rst_n) begin
    bit          m_valid;
    bit          m_pop;
    bit          m_push;
    logic [31:0] w;
    ent_t        e;
    if (!rst_n) begin
      mq.delete();
      mpc = RESET_PC;
    end else begin
      m_valid = (mq.size() != 0) && !redirect;
      m_pop   = m_valid && ready;
      m_push  = !redirect && ((mq.size() < DEPTH) || m_pop);
      if (redirect) begin
        mq.delete();
        mpc = {redirect_pc[31:1], 1'b0};
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          w     = word_at(mpc);
          e.pc  = mpc;
          e.c   = (w[1:0] != 2'b11);
          e.ins = e.c ? {16'h0000, w[15:0]} : w;
          mq.push_back(e);
          mpc = mpc + (e.c ? 32'd2 : 32'd4);
        end
      end
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    bit exp_valid;
    if (!rst_n) begin
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_is_c", {31'h0, is_c}, 32'h0);
      chk("rst_addr", imem_addr, RESET_PC);
    end else begin
      exp_valid = (mq.size() != 0) && !redirect;
      chk("valid", {31'h0, valid}, {31'h0, exp_valid});
      chk("addr", imem_addr, mpc);
      if (exp_valid && valid) begin
        chk("instr", instr, mq[0].ins);
        chk("pc", instr_pc, mq[0].pc);
        chk("is_c", {31'h0, is_c}, {31'h0, mq[0].c});
      end
    end
  end

  // Pulse a one-cycle redirect, then return at the falling edge after the flush.
  task automatic redirect_to(input logic [31:0] a);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = a;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc,
                             input logic [31:0] ins, input logic c);
    chk({name, "_valid"}, {31'h0, valid}, 32'h1);
    chk({name, "_pc"}, instr_pc, pc);
    chk({name, "_instr"}, instr, ins);
    chk({name, "_is_c"}, {31'h0, is_c}, {31'h0, c});
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = 1'b0;
    for (int i = 0; i < 1024; i++) mem_h[i] = 16'h0001;
    for (int k = 0; k < 16; k++) put32(32'(k * 4), 32'h0000_0013 | (32'(k) << 20));

    // Test 1: straight-line 32-bit code from reset, with decode always ready.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_head("t1", 32'(k * 4), 32'h0000_0013 | (32'(k) << 20), 1'b0);
    end

    // Test 2: mixed compressed and 32-bit stream starting at 0x40.
    put16(32'h40, 16'h4501);
    put16(32'h42, 16'h0513);
    put16(32'h44, 16'h0000);
    put16(32'h46, 16'h4585);
    redirect_to(32'h40);
    @(negedge clk); expect_head("t2a", 32'h40, 32'h0000_4501, 1'b1);
    @(negedge clk); expect_head("t2b", 32'h42, 32'h0000_0513, 1'b0);
    @(negedge clk); expect_head("t2c", 32'h46, 32'h0000_4585, 1'b1);

    // Test 3: back-pressure fills the FIFO and freezes the address.
    @(posedge clk); #1;
    ready = 1'b0;
    redirect_to(32'h0);
    repeat (10) @(negedge clk);
    chk("t3_addr_frozen", imem_addr, 32'h8);
    chk("t3_valid", {31'h0, valid}, 32'h1);
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk); chk("t3_pc0", instr_pc, 32'h0);
    @(negedge clk); chk("t3_pc4", instr_pc, 32'h4);
    @(negedge clk); chk("t3_pc8", instr_pc, 32'h8);

    // Test 4: redirect while full; the odd target bit is dropped.
    for (int k = 0; k < 4; k++) put32(32'h100 + 32'(k * 4), 32'h0010_0093 + 32'(k));
    @(posedge clk); #1;
    ready = 1'b0;
    redirect_to(32'h0);
    repeat (4) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h101;
    ready       = 1'b1;
    @(negedge clk);
    chk("t4_valid_in_redirect", {31'h0, valid}, 32'h0);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_valid_after", {31'h0, valid}, 32'h0);
    chk("t4_addr", imem_addr, 32'h100);
    @(negedge clk); expect_head("t4_first", 32'h100, 32'h0010_0093, 1'b0);

    // Test 5: asynchronous reset in the middle of a cycle.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_valid_now", {31'h0, valid}, 32'h0);
    chk("t5_instr_now", instr, 32'h0);
    chk("t5_addr_now", imem_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk); chk("t5_restart_pc", instr_pc, RESET_PC);

    // Test 6: fetch wraps from the top of the address space.
    put32(32'hFFFF_FFFC, 32'h00A0_0093);
    redirect_to(32'hFFFF_FFFC);
    @(negedge clk); expect_head("t6_top", 32'hFFFF_FFFC, 32'h00A0_0093, 1'b0);
    @(negedge clk); chk("t6_wrap_pc", instr_pc, 32'h0);

    // Randomized phase: random code, back-pressure, redirects and rare resets.
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
      mem_h[i] = h;
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst_n    = 1'b1;
      ready    = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    redirect = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
